// File: rtl/spi_frame_ctrl_pkg.sv
// spi_frame_ctrl_pkg: shared opcodes, FSM state codes and frame geometry defaults
package spi_frame_ctrl_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_FRAME_W = 3 + DEF_ADDR_W + DEF_DATA_W;
  localparam int OP_LSB = DEF_FRAME_W - 2;
  localparam int RSV_BIT = DEF_FRAME_W - 3;
  localparam int ADDR_LSB = DEF_DATA_W;
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ = 2'b10,
    OP_STATUS = 2'b11
  } op_e;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;
endpackage

// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if: frame handshakes from/to spi_slave plus the RAM access bus
interface spi_frame_ctrl_if import spi_frame_ctrl_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  localparam int FRAME_W = 3 + ADDR_W + DATA_W;
  logic rx_valid;
  logic [FRAME_W-1:0] rx_frame;
  logic rx_ready;
  logic tx_valid;
  logic [FRAME_W-1:0] tx_frame;
  logic tx_ready;
  logic ram_en;
  logic ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
    input rx_valid, rx_frame, tx_ready, ram_rdata,
    output rx_ready, tx_valid, tx_frame, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output rx_valid, rx_frame, tx_ready, ram_rdata,
    input rx_ready, tx_valid, tx_frame, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/spi_frame_ctrl_sat_cnt8.sv
// sat_cnt8: 8-bit event counter that sticks at 255
module sat_cnt8 (
  input logic clk,
  input logic rstn,
  input logic inc,
  output logic [7:0] cnt
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (inc && cnt != 8'hFF) cnt <= cnt + 8'd1;
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: decodes slave frames into RAM writes/reads and status responses
module spi_frame_ctrl import spi_frame_ctrl_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic rstn,
  spi_frame_ctrl_if.slave bus,
  output logic [7:0] wr_cnt,
  output logic [7:0] err_cnt
);
  localparam int FRAME_W = 3 + ADDR_W + DATA_W;
  logic [2:0] state, nxt;
  logic [FRAME_W-1:0] frame, resp;
  logic live;
  op_e op;
  logic rsv, bad;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  assign op = op_e'(frame[FRAME_W-1 -: 2]);
  assign rsv = frame[FRAME_W-3];
  assign addr = frame[DATA_W +: ADDR_W];
  assign data = frame[DATA_W-1:0];
  assign bad = rsv || ((op == OP_WRITE || op == OP_READ) && {1'b0, addr} >= (ADDR_W+1)'(DEPTH));
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = (bus.rx_valid && bus.rx_ready) ? S_DECODE : S_IDLE;
      S_DECODE: nxt = (bad || op == OP_NOP) ? S_IDLE : op == OP_WRITE ? S_WRITE :
                      op == OP_READ ? S_RD_ISSUE : S_RESP;
      S_RD_ISSUE: nxt = S_RD_WAIT;
      S_RD_WAIT: nxt = S_RESP;
      S_RESP: nxt = bus.tx_ready ? S_IDLE : S_RESP;
      default: nxt = S_IDLE;
    endcase
  end
  // live keeps rx_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= S_IDLE;
      live <= 1'b0;
      frame <= '0;
      resp <= '0;
    end else begin
      state <= nxt;
      live <= 1'b1;
      if (bus.rx_valid && bus.rx_ready) frame <= bus.rx_frame;
      if (state == S_RD_WAIT) resp <= {2'b10, 1'b0, addr, bus.ram_rdata};
      if (state == S_DECODE && !bad && op == OP_STATUS)
        resp <= {2'b11, 1'b0, {(FRAME_W-19){1'b0}}, err_cnt, wr_cnt};
    end
  assign bus.rx_ready = live && state == S_IDLE;
  assign bus.tx_valid = state == S_RESP;
  assign bus.tx_frame = resp;
  assign bus.ram_en = state == S_WRITE || state == S_RD_ISSUE;
  assign bus.ram_we = state == S_WRITE;
  assign bus.ram_addr = addr;
  assign bus.ram_wdata = data;
  sat_cnt8 u_wr_cnt (.clk(clk), .rstn(rstn), .inc(state == S_WRITE), .cnt(wr_cnt));
  sat_cnt8 u_err_cnt (.clk(clk), .rstn(rstn), .inc(state == S_DECODE && bad), .cnt(err_cnt));
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Command/memory controller directly downstream of spi_slave. Consumes each complete 32-bit frame deframed by the slave shifter and decodes it as NOP/WRITE/READ/STATUS. Performs the access on the slave-side 32x24 RAM and hands a response frame back to the slave shifter for transmission on the next SPI transaction. Runs entirely in the slave clock domain; sck/csn synchronisation is done upstream in spi_slave.

Parameters:
DATA_W, 24, RAM word width.
ADDR_W, 5, RAM address width.
DEPTH, 32, number of valid RAM words (DEPTH <= 2**ADDR_W); addresses >= DEPTH are errors.
FRAME_W (localparam), 2+1+ADDR_W+DATA_W = 32, frame width.

Ports:
clk  in  1  slave clock
rstn  in  1  asynchronous active-low reset
rx_valid  in  1  frame from spi_slave available
rx_frame  in  FRAME_W  {op[1:0], rsv, addr[ADDR_W-1:0], data[DATA_W-1:0]}
rx_ready  out  1  controller can accept a frame
tx_valid  out  1  response frame available
tx_frame  out  FRAME_W  response frame
tx_ready  in  1  spi_slave has loaded the response
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en with ram_we=0
wr_cnt  out  8  accepted writes, saturating
err_cnt  out  8  rejected frames, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset: all outputs 0, FSM in IDLE, captured frame register cleared. Asserting rstn low mid-operation aborts immediately. No RAM write is completed after reset. Any pending tx_valid drops.
- Opcodes: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
- FSM states: IDLE, DECODE, WRITE, RD_ISSUE, RD_WAIT, RESP.
- IDLE: rx_ready=1, asserted only in IDLE. rx_valid && rx_ready captures rx_frame -> DECODE next cycle.
- DECODE: error if rsv=1, or if op is WRITE/READ with addr >= DEPTH.
  - Error: err_cnt+1 (saturates at 255) -> IDLE.
  - NOP -> IDLE, no side effects.
  - WRITE -> WRITE.
  - READ -> RD_ISSUE.
  - STATUS -> RESP.
- WRITE: ram_en=ram_we=1 for exactly one cycle with addr/data from the frame; wr_cnt+1 (saturates at 255) -> IDLE. No response frame.
- RD_ISSUE: ram_en=1, ram_we=0 for one cycle -> RD_WAIT.
- RD_WAIT: capture ram_rdata -> RESP.
- RESP: tx_valid=1. tx_frame is held stable until tx_valid && tx_ready, then -> IDLE with tx_valid=0 in the next cycle.
  - READ response: {2'b10, 1'b0, addr, rdata}.
  - STATUS response: {2'b11, 1'b0, zeros, err_cnt, wr_cnt}, with counters in the low 16 bits.
- tx_ready high on the first RESP cycle: handshake completes that cycle.
- Latency, capture to RAM write strobe: 2 cycles.
- Latency, capture to tx_valid for READ: 4 cycles.
- ram_en=0 and ram_we=0 in every state except WRITE and RD_ISSUE.
- Only one frame is in flight; no buffering. spi_slave must hold rx_valid until rx_ready.

Decomposition:
- spi_pkg: opcode enum (OP_NOP/OP_WRITE/OP_READ/OP_STATUS), FSM state enum, frame field offsets, and FRAME_W/DATA_W/ADDR_W defaults shared with spi_master/spi_slave.
- One sub-module, sat_cnt8: 8-bit saturating counter with inc and rstn. Instantiated twice, for wr_cnt and err_cnt.

Test Plan:
- Reset: hold rstn=0 with rx_valid=1 -> all outputs 0, rx_ready=0 during reset; rx_ready=1 one cycle after release.
- Write: frame 0x4_1ABCDEF (op=01, addr=1, data=ABCDEF) -> exactly one cycle of ram_en=ram_we=1, ram_addr=1, ram_wdata=ABCDEF; wr_cnt=1; no tx_valid.
- Read: RAM[0]=FEDCBA, frame op=10 addr=0 -> ram_en pulse, ram_we=0; tx_frame=0x80FEDCBA with tx_valid after 4 cycles. Holding tx_ready=0 for 5 cycles keeps tx_frame stable; then rx_ready returns.
- Errors: frame with rsv=1, and a READ with addr>=DEPTH (DEPTH=24, addr=30) -> no RAM strobe, no tx_valid, err_cnt=2.
- Saturation and status: 260 writes, then STATUS -> tx_frame low 16 bits = 0x00FF, op bits = 11.
- Reset mid-read: drop rstn while in RD_WAIT -> tx_valid never asserted, FSM in IDLE, counters 0.
